// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared lane symbols, arbiter state encoding and lane word helpers
// Purpose: constants and helpers shared by lane_pkt_arbiter and skp_timer.
// Ports: none (package).
package pcie_phy_pkg;

  // One lane word is {valid, byte}.
  localparam int LANE_W = 9;
  typedef logic [LANE_W-1:0] lane_word_t;

  // K-symbols making up a SKP ordered set: one COM followed by SKP symbols.
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;

  // Ordered-set length in cycles and the index of its final cycle.
  localparam int         SKP_LEN  = 4;
  localparam logic [1:0] SKP_LAST = 2'(SKP_LEN - 1);

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT0 = 2'd1;
  localparam logic [1:0] ST_PKT1 = 2'd2;
  localparam logic [1:0] ST_SKP  = 2'd3;

  // Builds a valid lane word carrying the given symbol.
  function automatic lane_word_t lane_word(input logic [7:0] sym);
    return {1'b1, sym};
  endfunction

endpackage

// File: rtl/skp_timer.sv
// rtl/skp_timer.sv - free-running SKP interval timer with sticky pending flag
// Purpose: counts cycles since the last SKP ordered set and raises pending once
//   SKP_INTERVAL-1 is reached; the count then holds until the arbiter clears it.
// Ports:
//   clk      in  clock
//   reset    in  synchronous, active-low
//   clear    in  arbiter is entering SKP: restart count at 0, drop pending
//   pending  out an ordered set is owed at the next idle slot
module skp_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pending
);

  localparam int            CW      = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] LAST    = CW'(SKP_INTERVAL - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(SKP_INTERVAL - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      pending <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      pending <= 1'b0;
    end else if (count != LAST) begin
      // Pending rises on the same edge the count saturates, then stays
      // set because this branch is no longer taken.
      count   <= count + 1'b1;
      pending <= (count == LAST_M1);
    end
  end

endmodule

// File: rtl/lane_pkt_arbiter.sv
// rtl/lane_pkt_arbiter.sv - packet round-robin arbiter for the 2-lane transmit path with SKP insertion
// Purpose: grants whole packets alternately to two requesters, inserts SKP ordered
//   sets between packets when the timer asks, and registers the lane outputs.
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   req0_valid/ready         requester 0 beat handshake
//   req0_lane0/lane1         requester 0 lane words {valid,byte}
//   req0_eop                 requester 0 last beat of packet
//   req1_*                   same set for requester 1
//   out_lane0/lane1          registered lane words to the PHY
//   grant                    one-hot owner, 01 = req0, 10 = req1
//   skp_active               SKP ordered set on the outputs
//   err_overlong             pulse with the beat that hit MAX_BEATS without eop
module lane_pkt_arbiter
  import pcie_phy_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int MAX_BEATS    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [LANE_W-1:0] req0_lane0,
  input  logic [LANE_W-1:0] req0_lane1,
  input  logic              req0_eop,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [LANE_W-1:0] req1_lane0,
  input  logic [LANE_W-1:0] req1_lane1,
  input  logic              req1_eop,
  output logic [LANE_W-1:0] out_lane0,
  output logic [LANE_W-1:0] out_lane1,
  output logic [1:0]        grant,
  output logic              skp_active,
  output logic              err_overlong
);

  localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic [1:0]        state, state_next;
  logic              last_grant, last_grant_next;
  logic [CNT_W-1:0]  beat_count, beat_count_next, beat_inc;
  logic [1:0]        skp_idx, skp_idx_next;
  logic [LANE_W-1:0] lane0_next, lane1_next;
  logic              err_next;
  logic              skp_clear, skp_pending;

  // Signals of whichever requester currently owns the datapath.
  logic              own_id;
  logic              own_valid, own_eop;
  logic [LANE_W-1:0] own_lane0, own_lane1;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (skp_clear),
    .pending (skp_pending)
  );

  assign req0_ready = (state == ST_PKT0);
  assign req1_ready = (state == ST_PKT1);

  assign own_id    = (state == ST_PKT1);
  assign own_valid = own_id ? req1_valid : req0_valid;
  assign own_eop   = own_id ? req1_eop   : req0_eop;
  assign own_lane0 = own_id ? req1_lane0 : req0_lane0;
  assign own_lane1 = own_id ? req1_lane1 : req0_lane1;
  assign beat_inc  = beat_count + 1'b1;

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    beat_count_next = beat_count;
    skp_idx_next    = skp_idx;
    lane0_next      = '0;
    lane1_next      = '0;
    err_next        = 1'b0;
    skp_clear       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (skp_pending) begin
          state_next   = ST_SKP;
          skp_idx_next = '0;
          skp_clear    = 1'b1;
          lane0_next   = lane_word(K_COM);
          lane1_next   = lane_word(K_COM);
        end else if (last_grant) begin
          // req1 went last, so req0 gets first look.
          if (req0_valid)      state_next = ST_PKT0;
          else if (req1_valid) state_next = ST_PKT1;
        end else begin
          if (req1_valid)      state_next = ST_PKT1;
          else if (req0_valid) state_next = ST_PKT0;
        end
      end

      ST_PKT0, ST_PKT1: begin
        // No beat this cycle: ownership is kept and zero words go out.
        if (own_valid) begin
          lane0_next      = own_lane0;
          lane1_next      = own_lane1;
          beat_count_next = beat_inc;
          if (own_eop || (beat_inc == CNT_MAX)) begin
            state_next      = ST_IDLE;
            last_grant_next = own_id;
            beat_count_next = '0;
            err_next        = !own_eop;
          end
        end
      end

      default: begin
        if (skp_idx == SKP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          skp_idx_next = skp_idx + 1'b1;
          lane0_next   = lane_word(K_SKP);
          lane1_next   = lane_word(K_SKP);
        end
      end
    endcase
  end

  // grant and skp_active follow the next state so they line up with the
  // cycle in which the state (and therefore ready) is live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      beat_count   <= '0;
      skp_idx      <= '0;
      out_lane0    <= '0;
      out_lane1    <= '0;
      grant        <= 2'b00;
      skp_active   <= 1'b0;
      err_overlong <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      beat_count   <= beat_count_next;
      skp_idx      <= skp_idx_next;
      out_lane0    <= lane0_next;
      out_lane1    <= lane1_next;
      grant        <= {state_next == ST_PKT1, state_next == ST_PKT0};
      skp_active   <= (state_next == ST_SKP);
      err_overlong <= err_next;
    end
  end

endmodule

// File: tb/tb_lane_pkt_arbiter.sv
// tb/tb_lane_pkt_arbiter.sv - randomized self-checking bench for lane_pkt_arbiter
module tb_lane_pkt_arbiter;

  localparam int SKP_I = 16;
  localparam int MAXB  = 4;
  localparam int SKPN  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_eop;
  logic       req1_valid, req1_ready, req1_eop;
  logic [8:0] req0_lane0, req0_lane1, req1_lane0, req1_lane1;
  logic [8:0] out_lane0, out_lane1;
  logic [1:0] grant;
  logic       skp_active, err_overlong;

  always #5 clk = ~clk;

  lane_pkt_arbiter #(.SKP_INTERVAL(SKP_I), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lane0(req0_lane0),
    .req0_lane1(req0_lane1), .req0_eop(req0_eop),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lane0(req1_lane0),
    .req1_lane1(req1_lane1), .req1_eop(req1_eop),
    .out_lane0(out_lane0), .out_lane1(out_lane1), .grant(grant),
    .skp_active(skp_active), .err_overlong(err_overlong)
  );

  typedef struct packed {
    logic [8:0] l0;
    logic [8:0] l1;
    logic       eop;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    vprob0, vprob1;
  int    n_checks, n_pass;

  // Reference model: owner -1 = nobody, 0/1 = requester, 2 = SKP ordered set.
  int         m_owner, m_skp_left, m_beats, m_last, m_since;
  logic [8:0] e_l0, e_l1;
  logic [1:0] e_grant;
  logic       e_skp, e_err;

  function automatic logic [21:0] dut_o();
    return {out_lane0, out_lane1, grant, skp_active, err_overlong};
  endfunction

  function automatic logic [21:0] exp_o();
    return {e_l0, e_l1, e_grant, e_skp, e_err};
  endfunction

  function automatic logic [1:0] exp_rdy();
    return {m_owner == 1, m_owner == 0};
  endfunction

  task automatic push_pkt(input int who, input int len, input int tag, input bit with_eop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.l0  = {1'b1, 8'(tag + i)};
      b.l1  = {1'($urandom_range(1)), 8'($urandom_range(255))};
      b.eop = with_eop && (i == len - 1);
      if (who == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    req0_valid = (q0.size() > 0) && ($urandom_range(99) < vprob0);
    if (req0_valid) b = q0[0];
    else            b = beat_t'(19'($urandom));
    {req0_lane0, req0_lane1, req0_eop} = b;
    req1_valid = (q1.size() > 0) && ($urandom_range(99) < vprob1);
    if (req1_valid) b = q1[0];
    else            b = beat_t'(19'($urandom));
    {req1_lane0, req1_lane1, req1_eop} = b;
  endtask

  // Advances the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    bit    vld [2];
    beat_t b;
    int    n;
    vld[0] = req0_valid;
    vld[1] = req1_valid;
    e_err  = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_beats = 0; m_since = 0; m_skp_left = 0;
      e_l0 = '0; e_l1 = '0;
    end else if (m_owner == -1) begin
      e_l0 = '0; e_l1 = '0;
      if (m_since >= SKP_I - 1) begin
        m_owner = 2; m_skp_left = SKPN; m_since = 0;
        e_l0 = 9'h1BC; e_l1 = 9'h1BC;
      end else begin
        m_since++;
        if (vld[1 - m_last])  m_owner = 1 - m_last;
        else if (vld[m_last]) m_owner = m_last;
      end
    end else if (m_owner == 2) begin
      m_since++;
      m_skp_left--;
      if (m_skp_left == 0) begin
        m_owner = -1; e_l0 = '0; e_l1 = '0;
      end else begin
        e_l0 = 9'h11C; e_l1 = 9'h11C;
      end
    end else begin
      m_since++;
      n = m_owner;
      if (vld[n]) begin
        if (n == 0) b = q0.pop_front();
        else        b = q1.pop_front();
        e_l0 = b.l0; e_l1 = b.l1;
        m_beats++;
        if (b.eop || m_beats == MAXB) begin
          e_err = !b.eop; m_last = n; m_owner = -1; m_beats = 0;
        end
      end else begin
        e_l0 = '0; e_l1 = '0;
      end
    end
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_skp   = (m_owner == 2);
  endtask

  task automatic test_reset();
    push_pkt(0, 3, 8'h01, 1);
    push_pkt(1, 3, 8'h11, 1);
    drive();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== 22'h0) $display("FAIL reset_out got %h expected %h", dut_o(), 22'h0);
      else n_pass++;
      if (c == 3) rst_n = 1'b1;
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready got %b expected 00", {req1_ready, req0_ready});
      else n_pass++;
      model_step();
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01) $display("FAIL first_grant got %b expected 01", grant);
    else n_pass++;
    n_checks++;
    if (dut_o() !== exp_o()) $display("FAIL first_out got %h expected %h", dut_o(), exp_o());
    else n_pass++;
    drive(); #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL first_ready got %b expected %b", {req1_ready, req0_ready}, exp_rdy());
    else n_pass++;
    model_step();
  endtask

  task automatic test_drain(input string tag);
    int g = 0;
    vprob0 = 100; vprob1 = 100;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner != -1) && g < 300) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL %s_drain_out got %h expected %h", tag, dut_o(), exp_o());
      else n_pass++;
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL %s_drain_ready got %b expected %b", tag, {req1_ready, req0_ready}, exp_rdy());
      else n_pass++;
      model_step();
      g++;
    end
    n_checks++;
    if (g >= 300) $display("FAIL %s_drain_timeout got %0d cycles expected < 300", tag, g);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [1:0] last_g = 2'b01;
    logic [1:0] prev_g = 2'b01;
    vprob0 = 100; vprob1 = 100;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL alt_out got %h expected %h", dut_o(), exp_o());
      else n_pass++;
      if (grant !== 2'b00 && prev_g === 2'b00) begin
        n_checks++;
        if (grant === last_g) $display("FAIL alt_order got %b expected not %b", grant, last_g);
        else n_pass++;
        last_g = grant;
      end
      prev_g = grant;
      if (q0.size() < 3) push_pkt(0, 3, 8'h01, 1);
      if (q1.size() < 3) push_pkt(1, 3, 8'h11, 1);
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL alt_ready got %b expected %b", {req1_ready, req0_ready}, exp_rdy());
      else n_pass++;
      model_step();
    end
    test_drain("alt");
  endtask

  task automatic test_back_to_back();
    int zrun = 0;
    bit zskp = 0;
    bit started = 0;
    vprob0 = 100;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL b2b_out got %h expected %h", dut_o(), exp_o());
      else n_pass++;
      if (grant === 2'b00) begin
        zrun++;
        if (skp_active) zskp = 1;
      end else begin
        if (started && zrun > 0) begin
          n_checks++;
          if (!zskp && zrun != 1) $display("FAIL b2b_bubble got %0d idle cycles expected 1", zrun);
          else n_pass++;
        end
        if (grant !== 2'b01) begin
          n_checks++;
          $display("FAIL b2b_grant got %b expected 01", grant);
        end
        started = 1; zrun = 0; zskp = 0;
      end
      if (q0.size() < 3) push_pkt(0, $urandom_range(3, 1), 8'h30, 1);
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL b2b_ready got %b expected %b", {req1_ready, req0_ready}, exp_rdy());
      else n_pass++;
      model_step();
    end
    test_drain("b2b");
  endtask

  task automatic test_skp();
    int n_skp = 0;
    int srun = 0;
    logic prev_s = 1'b0;
    logic [1:0] prev_g = 2'b00;
    vprob0 = 70; vprob1 = 70;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL skp_out got %h expected %h", dut_o(), exp_o());
      else n_pass++;
      if (skp_active === 1'b1 && prev_s === 1'b0) begin
        n_skp++;
        srun = 0;
        n_checks++;
        if (prev_g !== 2'b00 || out_lane0 !== 9'h1BC) $display("FAIL skp_start got grant %b lane %h expected 00 1bc", prev_g, out_lane0);
        else n_pass++;
      end
      if (skp_active === 1'b1) srun++;
      if (skp_active === 1'b0 && prev_s === 1'b1) begin
        n_checks++;
        if (srun != SKPN) $display("FAIL skp_len got %0d expected %0d", srun, SKPN);
        else n_pass++;
      end
      prev_s = skp_active;
      prev_g = grant;
      if (q0.size() < 3) push_pkt(0, $urandom_range(4, 1), 8'h80, 1);
      if (q1.size() < 3) push_pkt(1, $urandom_range(4, 1), 8'hA0, 1);
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL skp_ready got %b expected %b", {req1_ready, req0_ready}, exp_rdy());
      else n_pass++;
      model_step();
    end
    n_checks++;
    if (n_skp < 2) $display("FAIL skp_seen got %0d expected >= 2", n_skp);
    else n_pass++;
    test_drain("skp");
  endtask

  task automatic test_overlong();
    int n_err = 0;
    bit pushed0 = 0;
    bit after_err = 0;
    bit next_done = 0;
    vprob0 = 100; vprob1 = 100;
    push_pkt(1, 8, 8'h40, 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL ovl_out got %h expected %h", dut_o(), exp_o());
      else n_pass++;
      if (grant === 2'b10 && !pushed0) begin
        push_pkt(0, 2, 8'h50, 1);
        pushed0 = 1;
      end
      if (err_overlong === 1'b1) begin
        n_err++;
        if (n_err == 1) begin
          n_checks++;
          if (grant !== 2'b00 || out_lane0 !== 9'h143) $display("FAIL ovl_cut got grant %b lane %h expected 00 143", grant, out_lane0);
          else n_pass++;
        end
        after_err = 1;
      end else if (after_err && !next_done && grant !== 2'b00) begin
        n_checks++;
        if (grant !== 2'b01) $display("FAIL ovl_next got %b expected 01", grant);
        else n_pass++;
        next_done = 1;
      end
      drive(); #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_rdy()) $display("FAIL ovl_ready got %b expected %b", {req1_ready, req0_ready}, exp_rdy());
      else n_pass++;
      model_step();
    end
    n_checks++;
    if (n_err != 2) $display("FAIL ovl_count got %0d expected 2", n_err);
    else n_pass++;
    test_drain("ovl");
  endtask

  task automatic test_reset_mid();
    int g = 0;
    vprob0 = 100; vprob1 = 100;
    push_pkt(0, 3, 8'h60, 1);
    push_pkt(1, 3, 8'h70, 1);
    while (!((m_owner == 0 || m_owner == 1) && m_beats == 1) && g < 100) begin
      @(negedge clk);
      n_checks++;
      if (dut_o() !== exp_o()) $display("FAIL rstmid_pre got %h expected %h", dut_o(), exp_o());
      else n_pass++;
      drive(); #1;
      model_step();
      g++;
    end
    n_checks++;
    if (g >= 100) $display("FAIL rstmid_reach got %0d cycles expected < 100", g);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut_o() !== exp_o()) $display("FAIL rstmid_beat1 got %h expected %h", dut_o(), exp_o());
    else n_pass++;
    rst_n = 1'b0;
    drive(); #1;
    model_step();
    @(negedge clk);
    n_checks++;
    if (dut_o() !== 22'h0 || {req1_ready, req0_ready} !== 2'b00)
      $display("FAIL rstmid_out got %h/%b expected 0/00", dut_o(), {req1_ready, req0_ready});
    else n_pass++;
    rst_n = 1'b1;
    drive(); #1;
    model_step();
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01) $display("FAIL rstmid_grant got %b expected 01", grant);
    else n_pass++;
    drive(); #1;
    model_step();
    test_drain("rstmid");
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    vprob0 = 100; vprob1 = 100;
    m_owner = -1; m_last = 1; m_beats = 0; m_since = 0; m_skp_left = 0;
    e_l0 = '0; e_l1 = '0; e_grant = 2'b00; e_skp = 1'b0; e_err = 1'b0;
    test_reset();
    test_alternate();
    test_back_to_back();
    test_skp();
    test_overlong();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
